// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core_state encoding seen by every per-thread unit,
// LSU/fetcher state codes and width helpers derived from the lane count.
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  localparam logic [2:0] FETCHER_IDLE     = 3'b000;
  localparam logic [2:0] FETCHER_FETCHING = 3'b001;
  localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

  // thread_count must hold the value T itself, hence one bit more than clog2
  function automatic int tc_bits(input int threads);
    return $clog2(threads) + 1;
  endfunction

  function automatic int lsu_bits(input int threads);
    return 2 * threads;
  endfunction

endpackage

// File: rtl/core_scheduler.sv
// Per-core control FSM: steps every lane through FETCH..UPDATE in lockstep, owns the
// shared PC, stalls on the fetcher and on active LSUs, and flags divergence and RET.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [tc_bits(THREADS_PER_BLOCK)-1:0]              thread_count,
  input  logic [2:0]                                         fetcher_state,
  input  logic [lsu_bits(THREADS_PER_BLOCK)-1:0]             lsu_state,
  input  logic                                               decoded_ret,
  input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                                         core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
  output logic                                               done,
  output logic                                               diverged,
  output logic [15:0]                                        retired_count
);

  localparam int T   = THREADS_PER_BLOCK;
  localparam int PA  = PROGRAM_MEM_ADDR_BITS;
  localparam int TCW = tc_bits(THREADS_PER_BLOCK);
  localparam logic [TCW-1:0] T_MAX = TCW'(T);

  core_state_t    state_q, state_d;
  logic [PA-1:0]  pc_q, pc_d;
  logic           done_q, done_d;
  logic           div_q, div_d;
  logic [15:0]    retired_q, retired_d;

  logic [TCW-1:0] active_cnt_s;
  logic [T-1:0]   lane_active_s;
  logic [T-1:0]   lane_busy_s;
  logic [T-1:0]   lane_last_s;
  logic [T-1:0]   lane_mismatch_s;
  logic [PA-1:0]  lane_pc_s [T];
  logic [PA-1:0]  last_pc_s;

  assign active_cnt_s = (thread_count > T_MAX) ? T_MAX : thread_count;

  genvar g;
  generate
    for (g = 0; g < T; g++) begin : g_lane
      assign lane_active_s[g] = (TCW'(g) < active_cnt_s);
      assign lane_last_s[g]   = (TCW'(g + 1) == active_cnt_s);
      assign lane_pc_s[g]     = next_pc[g*PA +: PA];
      assign lane_busy_s[g]   = lane_active_s[g] &&
                                ((lsu_state[2*g +: 2] == LSU_REQUESTING) ||
                                 (lsu_state[2*g +: 2] == LSU_WAITING));
      assign lane_mismatch_s[g] = lane_active_s[g] && !lane_last_s[g] &&
                                  (lane_pc_s[g] != last_pc_s);
    end
  endgenerate

  // One-hot select of the highest active lane's next_pc
  always_comb begin
    last_pc_s = '0;
    for (int i = 0; i < T; i++) begin
      last_pc_s = last_pc_s | (lane_last_s[i] ? lane_pc_s[i] : {PA{1'b0}});
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = done_q;
    div_d     = div_q;
    retired_d = retired_q;
    case (state_q)
      CS_IDLE: begin
        if (start) begin
          if (active_cnt_s == TCW'(0)) begin
            state_d = CS_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CS_FETCH;
            pc_d    = '0;
          end
        end
      end
      CS_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = CS_DECODE;
      CS_DECODE:  state_d = CS_REQUEST;
      CS_REQUEST: state_d = CS_WAIT;
      CS_WAIT:    if (!(|lane_busy_s)) state_d = CS_EXECUTE;
      CS_EXECUTE: state_d = CS_UPDATE;
      CS_UPDATE: begin
        retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
        if (decoded_ret) begin
          state_d = CS_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = CS_FETCH;
          // thread_count may drop to 0 mid-kernel; there is no lane to follow then
          if (active_cnt_s != TCW'(0)) pc_d = last_pc_s;
          if (|lane_mismatch_s) div_d = 1'b1;
        end
      end
      CS_DONE: state_d = CS_DONE;
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CS_IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      done_q    <= done_d;
      div_q     <= div_d;
      retired_q <= retired_d;
    end
  end

  assign core_state    = state_q;
  assign current_pc    = pc_q;
  assign done          = done_q;
  assign diverged      = div_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_core_scheduler;

  localparam int T  = 4;
  localparam int PA = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      thread_count;
  logic [2:0]      fetcher_state;
  logic [2*T-1:0]  lsu_state;
  logic            decoded_ret;
  logic [PA*T-1:0] next_pc;
  logic [2:0]      core_state;
  logic [PA-1:0]   current_pc;
  logic            done;
  logic            diverged;
  logic [15:0]     retired_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  core_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(PA)) dut (
    .clock(clock), .reset(reset), .start(start), .thread_count(thread_count),
    .fetcher_state(fetcher_state), .lsu_state(lsu_state), .decoded_ret(decoded_ret),
    .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
    .done(done), .diverged(diverged), .retired_count(retired_count)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic set_pcs(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3);
    next_pc = {p3, p2, p1, p0};
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; thread_count = 3'd4; fetcher_state = 3'b010;
    lsu_state = '0; decoded_ret = 1'b0; set_pcs(8'd1, 8'd1, 8'd1, 8'd1);
    tick(2);
    reset = 1'b0;
    n_cmp++; if (core_state !== 3'b000) begin n_err++; $display("FAIL reset_state: got %0d want 0", core_state); end
    n_cmp++; if (current_pc !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", current_pc); end
    n_cmp++; if ({done, diverged} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {done, diverged}); end
    n_cmp++; if (retired_count !== 16'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired_count); end
  endtask

  task automatic test_single_instr;
    logic [2:0] exp_seq [7];
    exp_seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick(1);
      n_cmp++; if (core_state !== exp_seq[i]) begin n_err++; $display("FAIL seq_step%0d: got %b want %b", i, core_state, exp_seq[i]); end
    end
    n_cmp++; if (current_pc !== 8'd1) begin n_err++; $display("FAIL seq_pc: got %0d want 1", current_pc); end
    n_cmp++; if (retired_count !== 16'd1) begin n_err++; $display("FAIL seq_retired: got %0d want 1", retired_count); end
    n_cmp++; if (diverged !== 1'b0) begin n_err++; $display("FAIL seq_diverged: got %b want 0", diverged); end
  endtask

  task automatic test_wait_stall;
    set_pcs(8'd2, 8'd2, 8'd2, 8'd2);
    tick(2);
    n_cmp++; if (core_state !== 3'b011) begin n_err++; $display("FAIL stall_request: got %b want 011", core_state); end
    lsu_state[5:4] = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      n_cmp++; if (core_state !== 3'b100) begin n_err++; $display("FAIL stall_wait%0d: got %b want 100", k, core_state); end
      if (k == 4) lsu_state[5:4] = 2'b00;
    end
    tick(1);
    n_cmp++; if (core_state !== 3'b101) begin n_err++; $display("FAIL stall_exec: got %b want 101", core_state); end
    tick(2);
    n_cmp++; if (current_pc !== 8'd2) begin n_err++; $display("FAIL stall_pc: got %0d want 2", current_pc); end
    // lanes 2 and 3 busy but outside thread_count=2: no stall, PC from lane 1
    thread_count = 3'd2;
    set_pcs(8'd3, 8'd3, 8'd9, 8'd9);
    tick(2);
    lsu_state[5:4] = 2'b10; lsu_state[7:6] = 2'b01;
    tick(1);
    n_cmp++; if (core_state !== 3'b100) begin n_err++; $display("FAIL tc2_wait: got %b want 100", core_state); end
    tick(1);
    n_cmp++; if (core_state !== 3'b101) begin n_err++; $display("FAIL tc2_exec: got %b want 101", core_state); end
    lsu_state = '0;
    tick(2);
    n_cmp++; if (current_pc !== 8'd3) begin n_err++; $display("FAIL tc2_pc: got %0d want 3", current_pc); end
    n_cmp++; if (diverged !== 1'b0) begin n_err++; $display("FAIL tc2_diverged: got %b want 0", diverged); end
    n_cmp++; if (retired_count !== 16'd3) begin n_err++; $display("FAIL tc2_retired: got %0d want 3", retired_count); end
  endtask

  task automatic test_divergence;
    thread_count = 3'd3;
    set_pcs(8'd9, 8'd9, 8'd7, 8'd4);
    tick(6);
    n_cmp++; if (current_pc !== 8'd7) begin n_err++; $display("FAIL div_pc: got %0d want 7", current_pc); end
    n_cmp++; if (diverged !== 1'b1) begin n_err++; $display("FAIL div_set: got %b want 1", diverged); end
    set_pcs(8'd8, 8'd8, 8'd8, 8'd8);
    tick(6);
    n_cmp++; if (current_pc !== 8'd8) begin n_err++; $display("FAIL div_pc2: got %0d want 8", current_pc); end
    n_cmp++; if (diverged !== 1'b1) begin n_err++; $display("FAIL div_sticky: got %b want 1", diverged); end
  endtask

  task automatic test_clamp;
    thread_count = 3'd7;
    set_pcs(8'h33, 8'h33, 8'h33, 8'h33);
    tick(6);
    n_cmp++; if (current_pc !== 8'h33) begin n_err++; $display("FAIL clamp_pc: got %0h want 33", current_pc); end
    n_cmp++; if (retired_count !== 16'd6) begin n_err++; $display("FAIL clamp_retired: got %0d want 6", retired_count); end
  endtask

  task automatic test_ret;
    thread_count = 3'd4;
    set_pcs(8'h50, 8'h50, 8'h50, 8'h50);
    tick(4);
    decoded_ret = 1'b1;
    tick(2);
    decoded_ret = 1'b0;
    n_cmp++; if (core_state !== 3'b111) begin n_err++; $display("FAIL ret_state: got %b want 111", core_state); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ret_done: got %b want 1", done); end
    n_cmp++; if (current_pc !== 8'h33) begin n_err++; $display("FAIL ret_pc: got %0h want 33", current_pc); end
    n_cmp++; if (retired_count !== 16'd7) begin n_err++; $display("FAIL ret_retired: got %0d want 7", retired_count); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    n_cmp++; if ({core_state, done} !== 4'b1111) begin n_err++; $display("FAIL done_ignores_start: got %b want 1111", {core_state, done}); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_cmp++; if ({core_state, done, diverged} !== 5'b00000) begin n_err++; $display("FAIL ret_reset: got %b want 00000", {core_state, done, diverged}); end
    n_cmp++; if ({current_pc, retired_count} !== 24'd0) begin n_err++; $display("FAIL ret_reset_cnt: got %0h want 0", {current_pc, retired_count}); end
  endtask

  task automatic test_reset_mid_wait;
    set_pcs(8'd5, 8'd5, 8'd5, 8'd5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    n_cmp++; if (current_pc !== 8'd5) begin n_err++; $display("FAIL mid_pc: got %0d want 5", current_pc); end
    tick(2);
    lsu_state[1:0] = 2'b01;
    tick(2);
    n_cmp++; if (core_state !== 3'b100) begin n_err++; $display("FAIL mid_wait: got %b want 100", core_state); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    lsu_state = '0;
    n_cmp++; if (core_state !== 3'b000) begin n_err++; $display("FAIL mid_reset_state: got %b want 000", core_state); end
    n_cmp++; if ({current_pc, retired_count} !== 24'd0) begin n_err++; $display("FAIL mid_reset_cnt: got %0h want 0", {current_pc, retired_count}); end
    thread_count = 3'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++; if ({core_state, done} !== 4'b1111) begin n_err++; $display("FAIL tc0_done: got %b want 1111", {core_state, done}); end
    tick(1);
    n_cmp++; if (core_state !== 3'b111) begin n_err++; $display("FAIL tc0_hold: got %b want 111", core_state); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_saturation;
    thread_count = 3'd1;
    set_pcs(8'd4, 8'd6, 8'd6, 8'd6);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    tick(6);
    n_cmp++; if (retired_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %0h want ffff", retired_count); end
    n_cmp++; if ({current_pc, diverged} !== {8'd4, 1'b0}) begin n_err++; $display("FAIL sat_pc_div: got %0h want 8", {current_pc, diverged}); end
    fetcher_state = 3'b001;
    tick(2);
    n_cmp++; if (core_state !== 3'b001) begin n_err++; $display("FAIL fetch_hold: got %b want 001", core_state); end
    fetcher_state = 3'b010;
    tick(1);
    n_cmp++; if (core_state !== 3'b010) begin n_err++; $display("FAIL fetch_release: got %b want 010", core_state); end
    tick(5);
    n_cmp++; if (retired_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %0h want ffff", retired_count); end
  endtask

  initial begin
    test_reset;
    test_single_instr;
    test_wait_stall;
    test_divergence;
    test_clamp;
    test_ret;
    test_reset_mid_wait;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
